ex_div: RTL and testbench
=========================

# ex_div

Multi-cycle integer divider for the execute stage. It consumes the operands registered by the ID/EX pipeline register and executes RV32M DIV/DIVU/REM/REMU with a 32-iteration restoring algorithm. While busy it holds the pipeline through the execute stage's hold logic. It returns a one-cycle result strobe tagged with the destination register.

## Interface

Parameters:
- XLEN, default 32: operand and result width; only 32 is supported.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset. Asynchronous, active-high.
- start_i, input, 1: request a division. Sampled only in IDLE.
- kill_i, input, 1: abort any operation (pipeline clear on jump/trap).
- op_i, input, 3: funct3. 100 = DIV, 101 = DIVU, 110 = REM, 111 = REMU.
- dividend_i, input, XLEN: rs1 value (op1 from ID/EX).
- divisor_i, input, XLEN: rs2 value (op2 from ID/EX).
- reg_waddr_i, input, 5: destination register.
- result_o, output, XLEN: quotient or remainder. Valid only while ready_o is high.
- ready_o, output, 1: one-cycle completion strobe.
- busy_o, output, 1: operation in progress; execute stage requests a hold.
- reg_waddr_o, output, 5: destination register captured at start.

## Operation

- States: IDLE, START, CALC, END. Encoded as a 2-bit enum.
- IDLE: start_i=1 and kill_i=0 latches op_i, both operands and reg_waddr_i, then moves to START. A start_i arriving in any other state is ignored.
- START: take the magnitudes of the operands when the op is signed (DIV/REM) and the operand is negative. Clear the remainder accumulator and load the quotient shift register. Next state is CALC, with the counter set to 31.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by one bit.
  - Trial-subtract the divisor using a 33-bit subtract.
  - If the result is non-negative, keep it and set the quotient LSB to 1.
  - Decrement the counter. Go to END after the step where the counter is 0, which gives exactly 32 CALC cycles.
- END: apply sign correction.
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
  - Drive result_o with the quotient (DIV/DIVU) or the remainder (REM/REMU), assert ready_o, then return to IDLE.
- Divide by zero: quotient = 0xFFFFFFFF with no sign correction; remainder = dividend. The natural restoring result gives this; sign correction is suppressed when the divisor is 0.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM gives 0. This falls out of 32-bit unsigned magnitudes without special-casing.
- kill_i in any state: IDLE on the next edge, no ready_o. If kill_i and start_i are both high in IDLE, kill_i wins.
- rst_i mid-operation: immediately IDLE, with all outputs at their reset values.

## Timing

- Reset values: result_o=0, ready_o=0, busy_o=0, reg_waddr_o=0, state=IDLE.
- start_i is sampled at the edge ending cycle N:
  - START in cycle N+1.
  - CALC in cycles N+2 to N+33.
  - END in cycle N+34.
  - IDLE in cycle N+35.
- busy_o is high in START and CALC (cycles N+1 to N+33). It is low in END, so the execute stage writes back and releases its hold in the same cycle.
- ready_o is high only in END. It is registered, with no combinational path from inputs to outputs.
- result_o and reg_waddr_o are stable throughout END. Outside END, result_o holds 0.
- A new start_i is accepted in the IDLE cycle N+35, giving a minimum back-to-back spacing of 35 cycles.

## Configuration

- DIV_ZERO_FAST_EN:
  - Defined: START detects divisor==0 and goes straight to END with the divide-by-zero result. ready_o is high in cycle N+2, and busy_o is high in N+1 only.
  - Undefined: divide-by-zero takes the full 32 CALC cycles.
- Results are identical with and without the macro; only latency differs.

## Structure

- tinyriscv_pkg holds:
  - funct3 constants INST_DIV, INST_DIVU, INST_REM, INST_REMU.
  - The typedef div_state_e for IDLE/START/CALC/END.
  - RegBus and RegAddrBus, already present.
- Single module. The datapath (33-bit subtractor, shift registers, 5-bit counter) is too small to justify a sub-module.

## Test plan

- DIVU 100 / 7, start in cycle N: busy_o high N+1 to N+33; ready_o high in N+34 only with result_o=14; reg_waddr_o matches the value given at start.
- REM 0xFFFFFFF9 (-7) / 2: result_o=0xFFFFFFFF (-1). DIV of the same operands: result_o=0xFFFFFFFD (-3).
- DIV 0x80000000 / 0xFFFFFFFF: result_o=0x80000000. REM of the same operands: result_o=0.
- DIV 5 / 0: result_o=0xFFFFFFFF. REMU 5 / 0: result_o=5. ready_o at N+2 with DIV_ZERO_FAST_EN defined, N+34 without.
- kill_i at cycle N+10: busy_o low from N+11, ready_o never asserts. A new start_i in N+11 completes normally at N+45.
- start_i pulsed with different operands at N+5: ignored; the first operation's result is unchanged at N+34.

Source files
------------

// File: rtl/tinyriscv_pkg.sv
// Shared definitions for the tinyriscv execute-stage divider.
//   RegBus / RegAddrBus : register data and register address widths
//   INST_DIV..INST_REMU : RV32M divide funct3 encodings
//   div_state_e         : divider sequencing states
package tinyriscv_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    CALC  = 2'd2,
    END   = 2'd3
  } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), 32-step restoring algorithm.
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i      : request, sampled only in IDLE
//   kill_i       : abort any operation, wins over start_i
//   op_i         : funct3 of the divide instruction
//   dividend_i   : rs1 value
//   divisor_i    : rs2 value
//   reg_waddr_i  : destination register
//   result_o     : quotient/remainder, valid while ready_o, else 0
//   ready_o      : one-cycle completion strobe
//   busy_o       : operation in progress (execute-stage hold)
//   reg_waddr_o  : destination register captured at start
// Optional build macro DIV_ZERO_FAST_EN: divide-by-zero skips the CALC phase.
module ex_div
  import tinyriscv_pkg::*;
#(
  parameter int unsigned XLEN = RegBus
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  kill_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       dividend_i,
  input  logic [XLEN-1:0]       divisor_i,
  input  logic [RegAddrBus-1:0] reg_waddr_i,
  output logic [XLEN-1:0]       result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic [RegAddrBus-1:0] reg_waddr_o
);

  localparam int unsigned CntW = 5;

  div_state_e            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [XLEN-1:0]       dvd_q, dvd_d;
  logic [XLEN-1:0]       dvs_q, dvs_d;
  logic [XLEN-1:0]       mdvs_q, mdvs_d;
  logic [XLEN-1:0]       rem_q, rem_d;
  logic [XLEN-1:0]       quo_q, quo_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [RegAddrBus-1:0] waddr_q, waddr_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic                  is_signed, is_rem;
  logic                  dvd_neg, dvs_neg, dvs_zero;
  logic [XLEN-1:0]       mag_dvd, mag_dvs;
  logic [XLEN:0]         trial;
  logic [XLEN-1:0]       step_quo, step_rem;
  logic [XLEN-1:0]       fix_quo, fix_rem;

  // Operand decode and magnitudes
  always_comb begin
    is_signed = (op_q == INST_DIV) || (op_q == INST_REM);
    is_rem    = (op_q == INST_REM) || (op_q == INST_REMU);
    dvd_neg   = is_signed && dvd_q[XLEN-1];
    dvs_neg   = is_signed && dvs_q[XLEN-1];
    dvs_zero  = (dvs_q == '0);
    mag_dvd   = dvd_neg ? (~dvd_q + XLEN'(1)) : dvd_q;
    mag_dvs   = dvs_neg ? (~dvs_q + XLEN'(1)) : dvs_q;
  end

  // One restoring step; a negative 33-bit trial means restore (keep shifted value)
  always_comb begin
    trial    = {rem_q, quo_q[XLEN-1]} - {1'b0, mdvs_q};
    step_quo = {quo_q[XLEN-2:0], ~trial[XLEN]};
    step_rem = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
    // Divide-by-zero keeps the all-ones quotient unsigned
    fix_quo  = ((dvd_neg ^ dvs_neg) && !dvs_zero) ? (~step_quo + XLEN'(1)) : step_quo;
    fix_rem  = dvd_neg ? (~step_rem + XLEN'(1)) : step_rem;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    mdvs_d   = mdvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    waddr_d  = waddr_q;
    result_d = '0;
    ready_d  = 1'b0;
    busy_d   = 1'b0;

    if (kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            op_d    = op_i;
            dvd_d   = dividend_i;
            dvs_d   = divisor_i;
            waddr_d = reg_waddr_i;
            busy_d  = 1'b1;
            state_d = START;
          end
        end
        START: begin
          quo_d  = mag_dvd;
          rem_d  = '0;
          mdvs_d = mag_dvs;
          cnt_d  = CntW'(XLEN - 1);
`ifdef DIV_ZERO_FAST_EN
          if (dvs_zero) begin
            result_d = is_rem ? dvd_q : '1;
            ready_d  = 1'b1;
            state_d  = END;
          end else begin
            busy_d  = 1'b1;
            state_d = CALC;
          end
`else
          busy_d  = 1'b1;
          state_d = CALC;
`endif
        end
        CALC: begin
          quo_d = step_quo;
          rem_d = step_rem;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            result_d = is_rem ? fix_rem : fix_quo;
            ready_d  = 1'b1;
            state_d  = END;
          end else begin
            busy_d = 1'b1;
          end
        end
        END: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      mdvs_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      waddr_q  <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      mdvs_q   <= mdvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign reg_waddr_o = waddr_q;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: randomized RV32M divides against an arithmetic model.
module tb_ex_div;

  localparam int MAXC = 60;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        kill_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic [4:0]  reg_waddr_o;

  ex_div dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .kill_i      (kill_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_waddr_i (reg_waddr_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .reg_waddr_o (reg_waddr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the last run_op
  int          r_cyc;
  int          r_cnt;
  int          busy_bad;
  int          res_nz;
  logic [31:0] r_res;
  logic [4:0]  r_wa;

  // RV32M reference semantics
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int  sa;
    int  sb;
    logic ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 0) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op at the current negedge; start sampled at the next posedge (cycle N).
  // Returns at the negedge of the cycle after completion (or after kill), ready for the next op.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input int kill_at, input int pulse_at);
    bit bv [0:MAXC+1];
    int last;
    int end_b;
    op_i        = op;
    dividend_i  = a;
    divisor_i   = b;
    reg_waddr_i = wa;
    start_i     = 1'b1;
    @(posedge clk_i);
    #1;
    start_i     = 1'b0;
    dividend_i  = $urandom;
    divisor_i   = $urandom;
    reg_waddr_i = 5'($urandom);
    r_cyc = 0; r_cnt = 0; res_nz = 0; busy_bad = 0; r_res = '0; r_wa = '0; last = 0;
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge clk_i);
      bv[k] = busy_o;
      if (ready_o) begin
        r_cnt++;
        if (r_cyc == 0) begin
          r_cyc = k;
          r_res = result_o;
          r_wa  = reg_waddr_o;
        end
      end else if (result_o !== 32'h0) begin
        res_nz++;
      end
      kill_i  = 1'b0;
      start_i = 1'b0;
      if (k == kill_at) kill_i = 1'b1;
      if (k == pulse_at) begin
        start_i     = 1'b1;
        op_i        = 3'($urandom);
        dividend_i  = $urandom;
        divisor_i   = $urandom;
        reg_waddr_i = 5'($urandom);
      end
      last = k;
      if (kill_at > 0 && k == kill_at + 1) break;
      if (kill_at == 0 && r_cyc != 0 && k == r_cyc + 1) break;
    end
    end_b = (kill_at > 0) ? kill_at : ((r_cyc > 0) ? r_cyc - 1 : MAXC);
    for (int k = 1; k <= last; k++)
      if (bv[k] != (k <= end_b)) busy_bad++;
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    logic [31:0] exp_r;
    int          exp_c;
    logic [4:0]  wa;
    wa    = 5'($urandom);
    exp_r = ref_div(op, a, b);
    exp_c = exp_lat(b);
    run_op(op, a, b, wa, 0, 0);
    n_tests++;
    if (r_res !== exp_r || r_cyc != exp_c || r_cnt != 1 || r_wa !== wa || busy_bad != 0 ||
        res_nz != 0) begin
      n_fail++;
      $display("FAIL %s op=%b a=%h b=%h: got res=%h ready@%0d cnt=%0d wa=%0d busy_bad=%0d res_nz=%0d, need res=%h ready@%0d cnt=1 wa=%0d",
               name, op, a, b, r_res, r_cyc, r_cnt, r_wa, busy_bad, res_nz, exp_r, exp_c, wa);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0; op_i = '0;
    dividend_i = '0; divisor_i = '0; reg_waddr_i = '0;
    repeat (3) @(negedge clk_i);
    n_tests++;
    if (result_o !== 32'h0 || ready_o !== 1'b0 || busy_o !== 1'b0 || reg_waddr_o !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_values: got res=%h rdy=%b busy=%b wa=%h, need all 0",
               result_o, ready_o, busy_o, reg_waddr_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_tests++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b rdy=%b, need 0 0", busy_o, ready_o);
    end
  endtask

  task automatic test_divu_basic();
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd13, 0, 0);
    n_tests++;
    if (r_cyc != 34 || r_cnt != 1) begin
      n_fail++;
      $display("FAIL divu_ready_timing: got ready@%0d count=%0d, need ready@34 count=1", r_cyc, r_cnt);
    end
    n_tests++;
    if (r_res !== 32'd14) begin
      n_fail++;
      $display("FAIL divu_result: got %h, need %h", r_res, 32'd14);
    end
    n_tests++;
    if (r_wa !== 5'd13) begin
      n_fail++;
      $display("FAIL divu_waddr: got %0d, need 13", r_wa);
    end
    n_tests++;
    if (busy_bad != 0 || res_nz != 0) begin
      n_fail++;
      $display("FAIL divu_busy_window: got %0d busy errors, %0d nonzero results outside END, need 0 0",
               busy_bad, res_nz);
    end
  endtask

  task automatic test_signed();
    check_op("rem_neg7_2",  OP_REM, 32'hFFFF_FFF9, 32'd2);
    check_op("div_neg7_2",  OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check_op("div_ovf",     OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("rem_ovf",     OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("div_7_neg2",  OP_DIV, 32'd7, 32'hFFFF_FFFE);
    check_op("rem_7_neg2",  OP_REM, 32'd7, 32'hFFFF_FFFE);
    check_op("divu_big",    OP_DIVU, 32'hFFFF_FFFF, 32'd1);
    check_op("remu_big",    OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000);
  endtask

  task automatic test_div_zero();
    check_op("div_5_0",     OP_DIV,  32'd5, 32'd0);
    check_op("remu_5_0",    OP_REMU, 32'd5, 32'd0);
    check_op("div_neg5_0",  OP_DIV,  32'hFFFF_FFFB, 32'd0);
    check_op("rem_neg5_0",  OP_REM,  32'hFFFF_FFFB, 32'd0);
    check_op("divu_0_0",    OP_DIVU, 32'd0, 32'd0);
  endtask

  task automatic test_kill();
    run_op(OP_DIV, 32'd1000, 32'd3, 5'd9, 10, 0);
    n_tests++;
    if (r_cnt != 0 || busy_bad != 0) begin
      n_fail++;
      $display("FAIL kill_mid_op: got ready count=%0d busy errors=%0d, need 0 0", r_cnt, busy_bad);
    end
    check_op("after_kill", OP_DIVU, 32'd1000, 32'd3);
    // kill beats start in IDLE
    start_i = 1'b1; kill_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd9; divisor_i = 32'd3;
    @(posedge clk_i);
    #1;
    start_i = 1'b0; kill_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      n_tests++;
      if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL kill_beats_start: got busy=%b rdy=%b, need 0 0", busy_o, ready_o);
      end
    end
  endtask

  task automatic test_ignore_start();
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd21, 0, 5);
    n_tests++;
    if (r_res !== 32'd14 || r_cyc != 34 || r_cnt != 1 || r_wa !== 5'd21) begin
      n_fail++;
      $display("FAIL ignore_start: got res=%h ready@%0d cnt=%0d wa=%0d, need res=%h ready@34 cnt=1 wa=21",
               r_res, r_cyc, r_cnt, r_wa, 32'd14);
    end
  endtask

  task automatic test_reset_mid();
    op_i = OP_DIV; dividend_i = 32'd77; divisor_i = 32'd5; reg_waddr_i = 5'd30; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 32'h0 || reg_waddr_o !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_mid_op: got busy=%b rdy=%b res=%h wa=%h, need all 0",
               busy_o, ready_o, result_o, reg_waddr_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    check_op("after_reset", OP_REM, 32'd77, 32'd5);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 30; i++) begin
      op = 3'(3'b100 | 3'($urandom_range(0, 3)));
      a  = rnd_operand();
      b  = rnd_operand();
      check_op("random", op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_kill();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
